sel_mux_pipe: RTL
=================

# sel_mux_pipe

Parametrised N-way, WIDTH-bit selector with one registered output stage and a 2-entry skid buffer under valid/ready handshake. It generalises the combinational 2:1/3:1 datapath selectors to any input count and decouples producer and consumer timing. Intended for datapath points that need a mux plus a register boundary with backpressure, such as operand select into a stallable execute stage.

## Interface
- WIDTH, 32: data width of each input and of the output.
- N, 3: number of data inputs; legal range 2..16.
- SEL_W, $clog2(N): select width; derived, not overridden.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input index; sampled with in_data.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts a beat; registered.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select value that produced out_data.
- out_err  output  1  sel was >= N for this beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts.

## Operation
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Selection: word = in[sel] for sel < N; sel >= N selects in[N-1] and sets the beat's err bit, matching the existing 3:1 default-to-last-input rule.
- Each beat stores {word, sel, err}; the three fields always travel together.
- Storage: output register (OR) and skid register (SK). State machine:
  - EMPTY: OR and SK invalid. Accept -> BUSY.
  - BUSY: OR valid. Accept without deliver -> FULL (beat into SK). Deliver without accept -> EMPTY. Both -> BUSY (new beat into OR).
  - FULL: OR and SK valid, in_ready=0. Deliver -> BUSY (SK moves into OR). No deliver -> stay.
- in_ready = (state != FULL), registered from next state; never depends combinationally on out_ready.
- out_valid = (state != EMPTY); out_data/out_sel/out_err driven from OR only.
- Beat order preserved; no beat dropped or duplicated.
- A beat offered while in_ready=0 is ignored; the producer must hold it.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): state EMPTY; out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1; SK cleared.
- Reset mid-operation: all held beats discarded; outputs take reset values immediately.
- Latency: beat accepted at edge t appears on out_* after edge t (valid in cycle t+1).
- Throughput: one beat per cycle sustained while out_ready=1.
- Backpressure: out_ready deasserted with OR full and a beat accepted the same cycle fills SK; in_ready drops one cycle later, so the skid absorbs exactly that one in-flight beat.
- While out_valid=1 and out_ready=0, out_data/out_sel/out_err are stable.
- Simultaneous accept and deliver in FULL cannot occur (in_ready=0).

## Structure
- Shared package sel_mux_pkg: state enum (EMPTY, BUSY, FULL) and a beat struct parametrised by WIDTH/SEL_W, or equivalent localparams; N range check as an elaboration-time assertion.
- One sub-module: pipe_skid (2-entry skid buffer, generic payload width) holding the state machine; top does selection and packs {word, sel, err} as payload WIDTH+SEL_W+1 bits.
- Selection is a purely combinational indexed read; no priority chain.

## Test plan
- Reset: assert rst_n=0 mid-stream with FULL state -> out_valid=0, in_ready=1, out_data=0 in the same cycle; no stale beat emitted after release.
- Selection, N=3, WIDTH=32: in={0xC,0xB,0xA} for k=0..2, sel=0,1,2 with out_ready=1 -> out_data 0xA,0xB,0xC one cycle after each accept, out_err=0.
- Out-of-range, N=3 (SEL_W=2): sel=3 -> out_data=in[2], out_sel=3, out_err=1.
- Backpressure: stream beats 1,2,3,4; out_ready=0 for 3 cycles from beat 1 output -> beat 2 held in SK, in_ready=0 from next cycle, beat 3 held by producer; on release output order 1,2,3,4, no loss.
- Throughput: 100 random beats, out_ready=1 -> 100 outputs in 101 cycles, in_ready constantly 1.
- Parameter sweep: N=2 (SEL_W=1), N=16 (SEL_W=4), WIDTH=8 and 64 with random valid/ready -> scoreboard match of {word, sel, err} per beat.

Source files
------------

// File: rtl/sel_mux_pkg.sv
// Shared types for the N-way selector pipeline: skid-buffer states, legal
// input-count range and the packed beat width.
package sel_mux_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // One beat is {word, sel, err}.
    function automatic int beat_width(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// Two-entry skid buffer (output register + skid register) under valid/ready.
// in_ready is registered, so it never depends combinationally on out_ready.
module pipe_skid
    import sel_mux_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    skid_state_e   state_q, state_d;
    logic [PW-1:0] or_q, sk_q;
    logic          accept, deliver;
    logic          load_or, load_sk, shift_sk;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = or_q;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        load_or  = 1'b0;
        load_sk  = 1'b0;
        shift_sk = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    load_or = 1'b1;
                end
            end
            BUSY: begin
                if (accept && !deliver) begin
                    state_d = FULL;
                    load_sk = 1'b1;
                end else if (!accept && deliver) begin
                    state_d = EMPTY;
                end else if (accept && deliver) begin
                    load_or = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d  = BUSY;
                    shift_sk = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
        end
    end

    // NOTE: the payload registers are reset because out_data must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q <= '0;
            sk_q <= '0;
        end else begin
            if (load_or) begin
                or_q <= in_data;
            end else if (shift_sk) begin
                or_q <= sk_q;
            end
            if (load_sk) begin
                sk_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-way WIDTH-bit selector feeding a registered skid buffer. Out-of-range
// selects fall back to the last input and flag the beat with err.
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 3,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int               PW    = beat_width(WIDTH, SEL_W);
    localparam int               N_M1  = N - 1;
    localparam logic [SEL_W:0]   N_LIM = N[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST  = N_M1[SEL_W-1:0];

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("sel_mux_pipe: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
    end

    logic [WIDTH-1:0] in_arr [N];
    logic             err;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] word;
    logic [PW-1:0]    in_beat, out_beat;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Plain indexed read; the extra select bit keeps the range compare exact for N=2^k.
    assign err     = ({1'b0, sel} >= N_LIM);
    assign idx     = err ? LAST : sel;
    assign word    = in_arr[idx];
    assign in_beat = {word, sel, err};

    pipe_skid #(
        .PW(PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_beat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_beat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign {out_data, out_sel, out_err} = out_beat;

endmodule
